// File: rtl/mem_wait_ctrl.sv
// -----------------------------------------------------------------------------
// mem_wait_ctrl
//
// Memory-stage controller that turns a single-cycle data-memory request from
// the EXE stage register into a multi-cycle access on a word-addressed external
// SRAM. While an access is in flight `ready` is low so the top level can freeze
// every pipeline register; `ready` rises for exactly one cycle (DONE) when the
// result is available and the pipeline may advance.
//
// Ports
//   clk          in   single clock, all state on rising edge
//   rst          in   asynchronous active-low reset
//   MEM_R_EN     in   load request
//   MEM_W_EN     in   store request (wins over MEM_R_EN when both are set)
//   address      in   byte address (ALU result)
//   data         in   store value
//   MEM_result   out  registered load data
//   ready        out  0 = freeze the pipeline this cycle
//   sram_addr    out  SRAM word address (latched at request time)
//   sram_wdata   out  SRAM write data (latched at request time)
//   sram_rdata   in   SRAM read data, valid in the last ACCESS cycle
//   sram_we_n    out  active-low write enable
//   sram_oe_n    out  active-low output enable
//   stall_count  out  saturating count of cycles with ready = 0
//
// SRAM_ADDR_W must not exceed 30 (a 32-bit byte address holds 30 word bits).
// WAIT_CYCLES must lie in 1..15 (4-bit access counter).
// -----------------------------------------------------------------------------
module mem_wait_ctrl #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SRAM_ADDR_W = 17,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   MEM_R_EN,
    input  logic                   MEM_W_EN,
    input  logic [31:0]            address,
    input  logic [DATA_W-1:0]      data,
    output logic [DATA_W-1:0]      MEM_result,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0]      sram_wdata,
    input  logic [DATA_W-1:0]      sram_rdata,
    output logic                   sram_we_n,
    output logic                   sram_oe_n,
    output logic [15:0]            stall_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [3:0]               r_count;
    logic                     r_is_write;
    logic [SRAM_ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]        r_wdata;
    logic [DATA_W-1:0]        r_result;
    logic [15:0]              r_stall;

    logic                     w_req;
    logic [31:0]              w_offset;
    logic [31:0]              w_word_full;
    logic                     w_in_range;
    logic [SRAM_ADDR_W-1:0]   w_word;
    logic                     w_last;

    assign w_req       = MEM_R_EN | MEM_W_EN;
    assign w_offset    = address - BASE_ADDR;
    // Byte offset to word index; the two byte-select bits are dropped.
    assign w_word_full = w_offset >> 2;
    // Below the base the subtraction wraps, so the lower bound is checked
    // explicitly; the upper bound is "no word bits above the SRAM width".
    assign w_in_range  = (address >= BASE_ADDR) &&
                         ((w_word_full >> SRAM_ADDR_W) == 32'd0);
    assign w_word      = w_word_full[SRAM_ADDR_W-1:0];
    assign w_last      = (r_count == LP_WAIT);

    // Next state, ready and strobes. Strobes are decoded from state so an
    // asynchronous reset drops them immediately, without waiting for an edge.
    always_comb begin
        w_state_next = r_state;
        ready        = 1'b1;
        sram_we_n    = 1'b1;
        sram_oe_n    = 1'b1;
        case (r_state)
            S_IDLE: begin
                // Freeze in the same cycle the request shows up.
                ready = ~w_req;
                if (w_req) begin
                    w_state_next = w_in_range ? S_ACCESS : S_DONE;
                end
            end
            S_ACCESS: begin
                ready     = 1'b0;
                sram_we_n = ~r_is_write;
                sram_oe_n = r_is_write;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_count    <= 4'd0;
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_result   <= '0;
            r_stall    <= 16'd0;
        end else begin
            r_state <= w_state_next;

            if (!ready && (r_stall != 16'hFFFF)) begin
                r_stall <= r_stall + 16'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_in_range) begin
                            // A simultaneous read+write is treated as a write.
                            r_is_write <= MEM_W_EN;
                            r_addr     <= w_word;
                            r_wdata    <= data;
                            r_count    <= 4'd1;
                        end else if (!MEM_W_EN) begin
                            // Out-of-range load returns zero; store is dropped.
                            r_result <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    r_count <= r_count + 4'd1;
                    if (w_last && !r_is_write) begin
                        r_result <= sram_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign MEM_result  = r_result;
    assign sram_addr   = r_addr;
    assign sram_wdata  = r_wdata;
    assign stall_count = r_stall;

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_wait_ctrl
//
// Each transaction is turned into its expected per-cycle output trace from the
// timing rules (stall length, strobe window, result-visible cycle) and queued;
// one compare process pops one entry per cycle on the falling edge and checks
// every output against it. A small SRAM responder stores writes and returns
// read data. Directed literal checks pin the model on the documented cases.
// -----------------------------------------------------------------------------
module tb_mem_wait_ctrl;

    localparam int          WAIT   = 4;
    localparam int          ADDR_W = 17;
    localparam logic [31:0] BASE   = 32'd1024;

    logic              clk;
    logic              rst;
    logic              MEM_R_EN;
    logic              MEM_W_EN;
    logic [31:0]       address;
    logic [31:0]       data;
    logic [31:0]       MEM_result;
    logic              ready;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata = '0;
    logic              sram_we_n;
    logic              sram_oe_n;
    logic [15:0]       stall_count;

    mem_wait_ctrl #(
        .DATA_W     (32),
        .SRAM_ADDR_W(ADDR_W),
        .BASE_ADDR  (BASE),
        .WAIT_CYCLES(WAIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MEM_R_EN   (MEM_R_EN),
        .MEM_W_EN   (MEM_W_EN),
        .address    (address),
        .data       (data),
        .MEM_result (MEM_result),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rdy;
        bit          we_n;
        bit          oe_n;
        bit          bus;
        int unsigned addr;
        logic [31:0] wdata;
        logic [31:0] result;
        int unsigned stall;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem[int];
    logic [31:0] resp_mem[int];
    logic [31:0] m_result = '0;
    int unsigned m_stall  = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cnt_we   = 0;
    int          cnt_oe   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=0x%0h want=0x%0h", name, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_get(input int w);
        return model_mem.exists(w) ? model_mem[w] : 32'd0;
    endfunction

    // SRAM responder: write on rising edge while we_n is low, present read
    // data half a cycle after the address settles.
    initial forever begin
        @(posedge clk);
        if (rst && !sram_we_n) resp_mem[int'(sram_addr)] = sram_wdata;
    end
    initial forever begin
        @(negedge clk);
        sram_rdata = resp_mem.exists(int'(sram_addr)) ? resp_mem[int'(sram_addr)] : 32'd0;
    end

    // Single compare process: one expected entry per cycle.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!sram_we_n) cnt_we++;
        if (!sram_oe_n) cnt_oe++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ready", 64'(ready), 64'(e.rdy));
            check("we_n", 64'(sram_we_n), 64'(e.we_n));
            check("oe_n", 64'(sram_oe_n), 64'(e.oe_n));
            check("result", 64'(MEM_result), 64'(e.result));
            check("stall", 64'(stall_count), 64'(e.stall));
            if (e.bus) begin
                check("sram_addr", 64'(sram_addr), 64'(e.addr));
                if (e.we_n == 1'b0) check("sram_wdata", 64'(sram_wdata), 64'(e.wdata));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_entry(input bit rdy, input bit we_n, input bit oe_n, input bit bus,
                              input int unsigned a, input logic [31:0] wd, input logic [31:0] res);
        exp_t e;
        e.rdy = rdy; e.we_n = we_n; e.oe_n = oe_n; e.bus = bus;
        e.addr = a; e.wdata = wd; e.result = res; e.stall = m_stall;
        exp_q.push_back(e);
        if (!rdy && m_stall < 65535) m_stall++;
    endtask

    // Drive one request (or an idle cycle when r=w=0) and queue its trace:
    // cycles 0..n-1 stalled, strobe in cycles 1..WAIT when in range, cycle n
    // ready with the new result visible.
    task automatic run_txn(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        longint      la;
        bit          in_rng;
        int unsigned word;
        bit          wr;
        bit          rd;
        bit          act;
        int          n;
        logic [31:0] newres;
        la     = longint'(a);
        in_rng = (la >= longint'(BASE)) && (((la - longint'(BASE)) / 4) < (longint'(1) << ADDR_W));
        word   = in_rng ? int'((la - longint'(BASE)) / 4) : 0;
        wr     = w;
        rd     = r && !w;
        n      = (r || w) ? (in_rng ? WAIT + 1 : 1) : 0;
        newres = rd ? (in_rng ? mem_get(int'(word)) : 32'd0) : m_result;
        if (wr && in_rng) model_mem[int'(word)] = d;
        MEM_R_EN = r; MEM_W_EN = w; address = a; data = d;
        for (int k = 0; k <= n; k++) begin
            act = in_rng && (wr || rd) && (k >= 1) && (k <= WAIT);
            push_entry(k == n, !(act && wr), !(act && rd), act, word, d,
                       (k == n) ? newres : m_result);
        end
        m_result = newres;
        repeat (n + 1) step();
    endtask

    initial begin
        int          we0;
        int          oe0;
        logic [31:0] a;
        logic [31:0] d;
        int          op;
        int          sel;

        rst = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; address = '0; data = '0;
        #1;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_we_n", 64'(sram_we_n), 64'd1);
        check("rst_oe_n", 64'(sram_oe_n), 64'd1);
        check("rst_result", 64'(MEM_result), 64'd0);
        check("rst_stall", 64'(stall_count), 64'd0);
        check("rst_addr", 64'(sram_addr), 64'd0);
        check("rst_wdata", 64'(sram_wdata), 64'd0);
        step(); step();
        rst = 1'b1;

        for (int i = 0; i < 10; i++) run_txn(1'b0, 1'b0, 32'd0, 32'd0);
        check("idle_stall", 64'(stall_count), 64'd0);

        // Store 0xDEADBEEF to byte 1028 (word 1).
        we0 = cnt_we; oe0 = cnt_oe;
        run_txn(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
        check("st_stall5", 64'(stall_count), 64'd5);
        check("st_we_cycles", 64'(cnt_we - we0), 64'd4);
        check("st_oe_cycles", 64'(cnt_oe - oe0), 64'd0);

        // Load it back.
        we0 = cnt_we; oe0 = cnt_oe;
        run_txn(1'b1, 1'b0, 32'd1028, 32'd0);
        check("ld_result", 64'(MEM_result), 64'hDEADBEEF);
        check("ld_oe_cycles", 64'(cnt_oe - oe0), 64'd4);
        check("ld_we_cycles", 64'(cnt_we - we0), 64'd0);
        check("ld_stall10", 64'(stall_count), 64'd10);

        // Out-of-range load: one stall cycle, no strobe, result forced to 0.
        we0 = cnt_we; oe0 = cnt_oe;
        run_txn(1'b1, 1'b0, 32'd512, 32'd0);
        check("oor_result", 64'(MEM_result), 64'd0);
        check("oor_stall11", 64'(stall_count), 64'd11);
        check("oor_strobes", 64'((cnt_we - we0) + (cnt_oe - oe0)), 64'd0);

        // Read+write together behaves as a write to word 2.
        run_txn(1'b1, 1'b1, 32'd1032, 32'h12345678);
        check("both_result", 64'(MEM_result), 64'd0);
        run_txn(1'b1, 1'b0, 32'd1032, 32'd0);
        check("both_readback", 64'(MEM_result), 64'h12345678);

        // Address boundaries.
        run_txn(1'b1, 1'b0, 32'd1023, 32'd0);
        run_txn(1'b0, 1'b1, BASE + 32'((1 << ADDR_W) - 1) * 32'd4 + 32'd3, 32'hA5A5_0001);
        run_txn(1'b1, 1'b0, BASE + 32'((1 << ADDR_W) - 1) * 32'd4, 32'd0);
        check("top_word", 64'(MEM_result), 64'hA5A5_0001);
        run_txn(1'b0, 1'b1, BASE + 32'(1 << ADDR_W) * 32'd4, 32'hFFFF_0000);

        // Randomised back-to-back traffic.
        for (int i = 0; i < 400; i++) begin
            op  = int'($urandom_range(0, 7));
            sel = int'($urandom_range(0, 9));
            case (sel)
                0:       a = $urandom_range(0, 1023);
                1:       a = BASE + 32'((1 << ADDR_W) - 1) * 32'd4 + $urandom_range(0, 3);
                2:       a = BASE + 32'(1 << ADDR_W) * 32'd4 + $urandom_range(0, 100);
                default: a = BASE + $urandom_range(0, 15) * 32'd4 + $urandom_range(0, 3);
            endcase
            d = $urandom;
            case (op)
                0:          run_txn(1'b0, 1'b0, a, d);
                1:          run_txn(1'b1, 1'b1, a, d);
                2, 3, 4:    run_txn(1'b1, 1'b0, a, d);
                default:    run_txn(1'b0, 1'b1, a, d);
            endcase
        end

        // Reset in the 2nd ACCESS cycle of a store to word 100.
        d = 32'hCAFE_F00D;
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b1; address = BASE + 32'd400; data = d;
        push_entry(1'b0, 1'b1, 1'b1, 1'b0, 0, d, m_result);
        push_entry(1'b0, 1'b0, 1'b1, 1'b1, 100, d, m_result);
        step(); step();
        #1 rst = 1'b0;
        #1;
        check("mid_rst_we_n", 64'(sram_we_n), 64'd1);
        check("mid_rst_oe_n", 64'(sram_oe_n), 64'd1);
        check("mid_rst_ready_req", 64'(ready), 64'd0);
        check("mid_rst_stall", 64'(stall_count), 64'd0);
        check("mid_rst_result", 64'(MEM_result), 64'd0);
        MEM_W_EN = 1'b0;
        #1;
        check("mid_rst_ready_idle", 64'(ready), 64'd1);
        step(); step();
        rst = 1'b1;
        m_stall  = 0;
        m_result = '0;
        run_txn(1'b0, 1'b1, BASE + 32'd12, 32'h0BAD_BEEF);
        check("post_rst_stall5", 64'(stall_count), 64'd5);
        run_txn(1'b1, 1'b0, BASE + 32'd12, 32'd0);
        check("post_rst_read", 64'(MEM_result), 64'h0BAD_BEEF);

        for (int i = 0; i < 3; i++) run_txn(1'b0, 1'b0, 32'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wait_ctrl.md
# mem_wait_ctrl

Parametrised memory-stage controller that replaces the single-cycle data memory of the SARM pipeline with a multi-cycle external SRAM access. It sits between the EXE stage register outputs and the MEM stage register, drives a word-addressed SRAM port with a configurable number of wait states, and returns `ready` so the top level can freeze every pipeline register while an access is in flight. A saturating stall counter is included for performance measurement.

## Interface
- `DATA_W`, 32: data width of store value, load result and SRAM data.
- `SRAM_ADDR_W`, 17: SRAM word-address width.
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.
- `WAIT_CYCLES`, 4: SRAM access cycles per request; legal range 1..15.
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `MEM_R_EN`  in  1  load request from EXE stage register.
- `MEM_W_EN`  in  1  store request from EXE stage register.
- `address`  in  32  byte address (ALU result).
- `data`  in  DATA_W  store value (ST_val).
- `MEM_result`  out  DATA_W  registered load data.
- `ready`  out  1  0 = freeze pipeline this cycle.
- `sram_addr`  out  SRAM_ADDR_W  SRAM word address.
- `sram_wdata`  out  DATA_W  SRAM write data.
- `sram_rdata`  in  DATA_W  SRAM read data, valid in the last ACCESS cycle.
- `sram_we_n`  out  1  active-low write enable.
- `sram_oe_n`  out  1  active-low output enable.
- `stall_count`  out  16  saturating count of cycles with `ready`=0.

## Operation
- Word address = (`address` − `BASE_ADDR`) >> 2; bits [1:0] ignored.
- In range: `address` ≥ `BASE_ADDR` and word address < 2^SRAM_ADDR_W. Otherwise out of range.
- States: IDLE, ACCESS, DONE.
- IDLE: `ready` = ~(`MEM_R_EN` | `MEM_W_EN`), combinational, so freeze asserts in the same cycle a request arrives.
  - Request and in range → latch op, word address and `data`; counter ← 1; go to ACCESS.
  - Request and out of range → go to DONE. No SRAM strobe. A read loads `MEM_result` ← 0.
- ACCESS: `ready`=0. `sram_addr`/`sram_wdata` are driven from the latched values.
  - Write: `sram_we_n`=0. Read: `sram_oe_n`=0.
  - Counter increments each cycle. When counter = `WAIT_CYCLES`: a read captures `sram_rdata` into `MEM_result`; go to DONE.
- DONE: `ready`=1 for exactly one cycle; strobes are high. Next state is IDLE unconditionally. The pipeline advances on this edge.
- Simultaneous `MEM_R_EN` and `MEM_W_EN`: treated as a write. `MEM_result` is unchanged.
- `MEM_result` changes only on a read completion (or an out-of-range read). Writes leave it unchanged.
- Request inputs are sampled only in IDLE. Changes during ACCESS/DONE are ignored; the frozen pipeline holds them stable.
- `stall_count` increments on every cycle with `ready`=0 and saturates at 65535.

## Timing
- Reset values (asynchronous, while `rst`=0):
  - State IDLE, counter 0.
  - `MEM_result`=0, `sram_addr`=0, `sram_wdata`=0.
  - `sram_we_n`=1, `sram_oe_n`=1, `stall_count`=0.
  - `ready` = ~(`MEM_R_EN` | `MEM_W_EN`).
- Reset mid-access: the access is abandoned and the strobes deassert immediately, without waiting for a clock edge.
- In-range request latency:
  - Request seen in IDLE at cycle 0.
  - ACCESS occupies cycles 1..WAIT_CYCLES.
  - DONE at cycle WAIT_CYCLES+1, with `MEM_result` valid and `ready`=1.
  - Total stall = WAIT_CYCLES+1 cycles.
- Out-of-range latency: 1 stall cycle (IDLE → DONE).
- Back-to-back requests: after DONE, IDLE is evaluated on the next cycle. There is a 0-cycle gap in `ready`, only the one DONE cycle of `ready`=1.
- No request: `ready`=1 continuously, and `stall_count` holds.

## Test plan
- Reset then idle, inputs all 0 → `ready`=1, strobes high, `MEM_result`=0, `stall_count`=0 for 10 cycles.
- WAIT_CYCLES=4, store `address`=1028, `data`=0xDEADBEEF →
  - `ready`=0 for 5 cycles.
  - `sram_we_n`=0 for exactly 4 cycles with `sram_addr`=1 and `sram_wdata`=0xDEADBEEF.
  - `ready`=1 on cycle 6.
  - `stall_count`=5.
- Load `address`=1028, SRAM model returns 0xDEADBEEF →
  - `sram_oe_n`=0 for 4 cycles.
  - `MEM_result`=0xDEADBEEF in the DONE cycle.
  - `sram_we_n` stays 1 throughout.
- Load `address`=512 (out of range) → `ready`=0 for 1 cycle, no strobe, `MEM_result`=0.
- `MEM_R_EN`=`MEM_W_EN`=1 with `address`=1032 → a write to word 2 occurs; `MEM_result` retains its prior value.
- Assert `rst`=0 in the 2nd ACCESS cycle → the same cycle shows `sram_we_n`=1, `ready`=~request, `stall_count`=0. After release, a fresh request takes the full 5 cycles.
